// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo
//   Byte FIFO that sits in front of the RS-232 serializer. Local writers push
//   bytes with wr_en/wr_data. The FIFO hands bytes to the serializer one at a
//   time over a tx_req/tx_data/tx_ack handshake. Bursty writers are absorbed
//   here while the serial line drains slowly.
//
// Ports
//   clk, rst_n        clock; reset is asynchronous and active-low
//   wr_en, wr_data    write strobe and byte. A write while full is dropped.
//   full, empty       decoded from the registered level
//   level             number of bytes stored (P_ADDR_W+1 bits)
//   tx_req, tx_data   byte offered to the serializer (registered)
//   tx_ack            one-cycle accept pulse from the serializer
//   ovf, ovf_cnt      sticky drop flag and saturating drop count
//   ovf_clr           clears ovf and ovf_cnt
//
// Build option
//   RS232_TX_FIFO_OVF_EN : define to enable overflow tracking. When it is
//   undefined, ovf and ovf_cnt read 0 and ovf_clr is ignored.

module rs232_tx_fifo #(
   parameter int P_ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [7:0]        wr_data,
   output logic              full,
   output logic              empty,
   output logic [P_ADDR_W:0] level,
   output logic              tx_req,
   output logic [7:0]        tx_data,
   input  logic              tx_ack,
   output logic              ovf,
   output logic [7:0]        ovf_cnt,
   input  logic              ovf_clr
);

   localparam int                DEPTH    = 2**P_ADDR_W;
   localparam logic [P_ADDR_W:0] LVL_FULL = (P_ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP} state_t;

   logic [7:0]          mem [DEPTH];
   logic [P_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [P_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [P_ADDR_W:0]   level_q, level_d;
   state_t              state_q, state_d;
   logic                tx_req_q, tx_req_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                wr_acc, pop;

   assign full    = (level_q == LVL_FULL);
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign tx_req  = tx_req_q;
   assign tx_data = tx_data_q;

   // Full is judged on the pre-edge level. A pop on the same edge does not
   // rescue a write made at full.
   assign wr_acc  = wr_en & ~full;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
   end

   // Read FSM. The byte counts as gone on the ack edge. S_GAP forces at least
   // one low cycle on tx_req between bytes.
   always_comb begin
      state_d   = state_q;
      tx_req_d  = tx_req_q;
      tx_data_d = tx_data_q;
      rd_ptr_d  = rd_ptr_q;
      pop       = 1'b0;
      case (state_q)
         S_IDLE: if (level_q != '0) begin
            tx_data_d = mem[rd_ptr_q];
            tx_req_d  = 1'b1;
            state_d   = S_REQ;
         end
         S_REQ: if (tx_ack) begin
            tx_req_d = 1'b0;
            rd_ptr_d = rd_ptr_q + 1'b1;
            pop      = 1'b1;
            state_d  = S_GAP;
         end
         S_GAP: state_d = S_IDLE;
         default: begin
            state_d  = S_IDLE;
            tx_req_d = 1'b0;
         end
      endcase
   end

   always_comb begin
      level_d = level_q;
      case ({wr_acc, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Storage is not reset. The pointers and the level define what is valid.
   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         state_q   <= S_IDLE;
         tx_req_q  <= 1'b0;
         tx_data_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         state_q   <= state_d;
         tx_req_q  <= tx_req_d;
         tx_data_q <= tx_data_d;
      end
   end

`ifdef RS232_TX_FIFO_OVF_EN
   logic       drop;
   logic       ovf_q, ovf_d;
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   assign drop = wr_en & full;

   // A clear on the same edge as a drop restarts the count at that drop.
   always_comb begin
      ovf_d     = ovf_q;
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_clr) begin
         ovf_d     = drop;
         ovf_cnt_d = drop ? 8'd1 : 8'd0;
      end else if (drop) begin
         ovf_d = 1'b1;
         if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q     <= 1'b0;
         ovf_cnt_q <= '0;
      end else begin
         ovf_q     <= ovf_d;
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf     = ovf_q;
   assign ovf_cnt = ovf_cnt_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
   assign ovf_cnt        = '0;
`endif

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// tb_rs232_tx_fifo
//   Directed bench for rs232_tx_fifo with P_ADDR_W=4 (16 bytes). Inputs change
//   1 time unit after each rising edge, and outputs are sampled at that point.
//   Overflow expectations follow RS232_TX_FIFO_OVF_EN.

module tb_rs232_tx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full, empty;
   logic [4:0] level;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       tx_ack;
   logic       ovf;
   logic [7:0] ovf_cnt;
   logic       ovf_clr;

   int n_chk = 0;
   int n_err = 0;

`ifdef RS232_TX_FIFO_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   rs232_tx_fifo #(.P_ADDR_W(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .full    (full),
      .empty   (empty),
      .level   (level),
      .tx_req  (tx_req),
      .tx_data (tx_data),
      .tx_ack  (tx_ack),
      .ovf     (ovf),
      .ovf_cnt (ovf_cnt),
      .ovf_clr (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (tx_req !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk(tag, 32'(tx_req), 32'd1);
   endtask

   task automatic ack();
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      tx_ack  = 1'b0;
      ovf_clr = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // 1: reset state
      chk("rst_tx_req",  32'(tx_req),  32'd0);
      chk("rst_empty",   32'(empty),   32'd1);
      chk("rst_full",    32'(full),    32'd0);
      chk("rst_level",   32'(level),   32'd0);
      chk("rst_ovf",     32'(ovf),     32'd0);
      chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);

      // 2: one byte, request appears after the edge following the write
      push(8'h55);
      chk("t2_lvl1",     32'(level),   32'd1);
      chk("t2_noreq_n",  32'(tx_req),  32'd0);
      tick();
      chk("t2_req",      32'(tx_req),  32'd1);
      chk("t2_data",     32'(tx_data), 32'h55);
      tick();
      chk("t2_hold_req", 32'(tx_req),  32'd1);
      chk("t2_hold_lvl", 32'(level),   32'd1);
      ack();
      chk("t2_ack_req",  32'(tx_req),  32'd0);
      chk("t2_ack_lvl",  32'(level),   32'd0);
      chk("t2_empty",    32'(empty),   32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t2_no2nd", 32'(tx_req), 32'd0);
      end

      // 3: burst of three, serializer acks 5 cycles after each request
      push(8'hA1);
      push(8'hB2);
      push(8'hC3);
      begin
         logic [7:0] exp3 [3];
         exp3[0] = 8'hA1; exp3[1] = 8'hB2; exp3[2] = 8'hC3;
         for (int k = 0; k < 3; k++) begin
            wait_req("t3_req");
            chk("t3_data", 32'(tx_data), 32'(exp3[k]));
            repeat (5) tick();
            chk("t3_stable", 32'(tx_data), 32'(exp3[k]));
            ack();
            chk("t3_gap", 32'(tx_req), 32'd0);
         end
      end
      chk("t3_lvl_end", 32'(level), 32'd0);

      // 4: fill with 00..0F, then 8'hEE is dropped
      for (int i = 0; i < 16; i++) push(8'(i));
      chk("t4_full",  32'(full),  32'd1);
      chk("t4_level", 32'(level), 32'd16);
      chk("t4_empty", 32'(empty), 32'd0);
      push(8'hEE);
      chk("t4_lvl_drop", 32'(level),   32'd16);
      chk("t4_ovf",      32'(ovf),     OVF_EN ? 32'd1 : 32'd0);
      chk("t4_ovf_cnt",  32'(ovf_cnt), OVF_EN ? 32'd1 : 32'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t4_clr_ovf", 32'(ovf),     32'd0);
      chk("t4_clr_cnt", 32'(ovf_cnt), 32'd0);
      // a drop on the same edge as a clear counts once
      ovf_clr = 1'b1;
      push(8'hEE);
      ovf_clr = 1'b0;
      chk("t4_clrdrop_ovf", 32'(ovf),     OVF_EN ? 32'd1 : 32'd0);
      chk("t4_clrdrop_cnt", 32'(ovf_cnt), OVF_EN ? 32'd1 : 32'd0);
      // 300 more drops saturate the count at 8'hFF
      wr_en   = 1'b1;
      wr_data = 8'hEE;
      repeat (300) tick();
      wr_en = 1'b0;
      chk("t4_sat_cnt", 32'(ovf_cnt), OVF_EN ? 32'hFF : 32'd0);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      chk("t4_clr2_cnt", 32'(ovf_cnt), 32'd0);
      // drain: expect exactly 00..0F in order, so 8'hEE never shows up
      for (int i = 0; i < 16; i++) begin
         wait_req("t4_drain_req");
         chk("t4_drain_data", 32'(tx_data), 32'(i));
         ack();
      end
      chk("t4_drain_lvl", 32'(level), 32'd0);

      // 5: write and ack on the same edge with level 1
      push(8'h77);
      wait_req("t5_req");
      chk("t5_lvl1", 32'(level), 32'd1);
      wr_en   = 1'b1;
      wr_data = 8'h88;
      tx_ack  = 1'b1;
      tick();
      wr_en  = 1'b0;
      tx_ack = 1'b0;
      chk("t5_lvl_same", 32'(level),  32'd1);
      chk("t5_req_low",  32'(tx_req), 32'd0);
      wait_req("t5_req2");
      chk("t5_data2", 32'(tx_data), 32'h88);
      ack();
      chk("t5_lvl_end", 32'(level), 32'd0);

      // 6: asynchronous reset while a request is up with level 5
      for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
      wait_req("t6_req");
      chk("t6_lvl5", 32'(level), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_req", 32'(tx_req), 32'd0);
      chk("t6_async_lvl", 32'(level),  32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_lvl",   32'(level), 32'd0);
      chk("t6_empty", 32'(empty), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_req", 32'(tx_req), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
